// File: rtl/train_led_tx.sv
// Serial transmitter for a chain of three-LED nodes using a pulse-width bit code.
// Each 12-bit node word goes out MSB first. A bit period starts high: the high time is long
// for a '1' and short for a '0', and the rest of the period is low. A one-word holding
// buffer lets the host queue the next word so that consecutive words stream with no gap.
// A frame ends with a long low latch gap.
// Supported parameter range: 1 <= T0H < T1H < TBIT and TLATCH >= 2*TBIT.
module train_led_tx #(
  parameter int unsigned T0H    = 2,
  parameter int unsigned T1H    = 6,
  parameter int unsigned TBIT   = 8,
  parameter int unsigned TLATCH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] wr_data,
  input  logic        wr_last,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic        dout,
  output logic        busy,
  output logic        underrun
);

  localparam int unsigned CntMax = (TBIT > TLATCH) ? TBIT : TLATCH;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  // Terminal counts: the counter value seen in the final cycle of each phase.
  localparam logic [CntW-1:0] T0hEnd   = CntW'(T0H - 1);
  localparam logic [CntW-1:0] T1hEnd   = CntW'(T1H - 1);
  localparam logic [CntW-1:0] TbitEnd  = CntW'(TBIT - 1);
  localparam logic [CntW-1:0] LatchEnd = CntW'(TLATCH - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [1:0] {StIdle, StHigh, StLow, StLatch} state_e;

  state_e            state_q;
  logic [11:0]       buf_data_q;
  logic              buf_last_q;
  logic              buf_full_q;
  logic [11:0]       sr_q;
  logic              sr_last_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [3:0]        bit_idx_q;
  logic              dout_q;
  logic              underrun_q;

  logic              wr_fire;
  logic [CntW-1:0]   high_end;

  assign wr_fire  = wr_valid && !buf_full_q;
  // The current bit always sits in the MSB of the shift register.
  assign high_end = sr_q[11] ? T1hEnd : T0hEnd;

  // Holding buffer and transmit FSM share one block: a load empties the buffer and a write
  // fills it, and the two can never coincide because a write needs the buffer empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      buf_data_q <= '0;
      buf_last_q <= 1'b0;
      buf_full_q <= 1'b0;
      sr_q       <= '0;
      sr_last_q  <= 1'b0;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      dout_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;

      if (wr_fire) begin
        buf_data_q <= wr_data;
        buf_last_q <= wr_last;
        buf_full_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          dout_q <= 1'b0;
          if (buf_full_q) begin
            sr_q       <= buf_data_q;
            sr_last_q  <= buf_last_q;
            buf_full_q <= 1'b0;
            bit_idx_q  <= '0;
            bit_cnt_q  <= '0;
            dout_q     <= 1'b1;
            state_q    <= StHigh;
          end
        end

        StHigh: begin
          bit_cnt_q <= bit_cnt_q + CntOne;
          if (bit_cnt_q == high_end) begin
            dout_q  <= 1'b0;
            state_q <= StLow;
          end
        end

        StLow: begin
          bit_cnt_q <= bit_cnt_q + CntOne;
          if (bit_cnt_q == TbitEnd) begin
            bit_cnt_q <= '0;
            if (bit_idx_q != 4'd11) begin
              sr_q      <= {sr_q[10:0], 1'b0};
              bit_idx_q <= bit_idx_q + 4'd1;
              dout_q    <= 1'b1;
              state_q   <= StHigh;
            end else if (!sr_last_q && buf_full_q) begin
              // Next word already queued: continue without any gap.
              sr_q       <= buf_data_q;
              sr_last_q  <= buf_last_q;
              buf_full_q <= 1'b0;
              bit_idx_q  <= '0;
              dout_q     <= 1'b1;
              state_q    <= StHigh;
            end else begin
              // Either a proper frame end or the host failed to keep up; both latch.
              underrun_q <= !sr_last_q;
              state_q    <= StLatch;
            end
          end
        end

        StLatch: begin
          bit_cnt_q <= bit_cnt_q + CntOne;
          if (bit_cnt_q == LatchEnd) begin
            bit_cnt_q <= '0;
            state_q   <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
          dout_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready = !buf_full_q;
  assign dout     = dout_q;
  assign busy     = (state_q != StIdle) || buf_full_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_train_led_tx.sv
// Bench for train_led_tx. The driver pushes each accepted word, with the cycle at which it
// was accepted, into a scoreboard queue. An independent monitor decodes dout into words
// and pops the queue to compare data, start cycle, frame-end behaviour and underrun.
module tb_train_led_tx;

  localparam int T0H    = 2;
  localparam int T1H    = 6;
  localparam int TBIT   = 8;
  localparam int TLATCH = 64;
  localparam int WORD_CYC = 12 * TBIT;

  logic        clk;
  logic        rst;
  logic [11:0] wr_data;
  logic        wr_last;
  logic        wr_valid;
  logic        wr_ready;
  logic        dout;
  logic        busy;
  logic        underrun;

  train_led_tx #(
    .T0H    (T0H),
    .T1H    (T1H),
    .TBIT   (TBIT),
    .TLATCH (TLATCH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_last  (wr_last),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .dout     (dout),
    .busy     (busy),
    .underrun (underrun)
  );

  typedef struct {
    logic [11:0] data;
    logic        last;
    int          acc;   // rising edge at which the word entered the buffer
  } exp_t;

  exp_t sb_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;   // number of rising edges so far

  // Monitor state
  int          mon_mode  = 0;   // 0: waiting for a word to start, 1: decoding a word
  int          gap_e     = 0;   // edge at which the transmitter is idle again
  int          under_cyc = -1;  // sample cycle at which underrun must be high
  int          busy_cyc  = -1;  // idle cycle at which busy is checked
  int          bit_i, bit_pos, hi_cnt, exp_start, w_end;
  bit          seen_low, shape_bad;
  logic [11:0] w_bits;
  exp_t        cur;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; returns at a falling edge after the transfer.
  task automatic send(input logic [11:0] d, input logic l);
    int guard;
    guard    = 0;
    wr_data  = d;
    wr_last  = l;
    wr_valid = 1'b1;
    while (!wr_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", int'(wr_ready), 1);
    if (wr_ready) sb_q.push_back('{data: d, last: l, acc: cyc + 1});
    @(negedge clk);
    wr_valid = 1'b0;
    wr_data  = 12'($urandom);
    wr_last  = 1'($urandom);
  endtask

  task automatic wait_idle(input int bound);
    int  k;
    bit  done;
    k    = 0;
    done = 0;
    while (!done && k < bound) begin
      @(posedge clk);
      k++;
      done = (sb_q.size() == 0) && (mon_mode == 0) && (cyc > gap_e + 1);
    end
    check("drain_done", int'(done), 1);
    @(negedge clk);
  endtask

  // Monitor: decodes dout and compares against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_mode  = 0;
        gap_e     = cyc;
        under_cyc = -1;
        busy_cyc  = -1;
        sb_q.delete();
      end else begin
        if (underrun || cyc == under_cyc)
          check("underrun", int'(underrun), int'(cyc == under_cyc));

        if (mon_mode == 0) begin
          if (cyc == busy_cyc)
            check("busy_idle", int'(busy), int'(sb_q.size() > 0 && sb_q[0].acc <= cyc));
          if (dout) begin
            if (sb_q.size() == 0) begin
              check("spurious_word", 1, 0);
              cur = '{data: 12'h0, last: 1'b1, acc: 0};
            end else begin
              exp_start = ((gap_e > sb_q[0].acc) ? gap_e : sb_q[0].acc) + 1;
              check("word_start", cyc, exp_start);
              cur = sb_q.pop_front();
            end
            check("ready_at_start", int'(wr_ready), 1);
            check("busy_at_start", int'(busy), 1);
            bit_i     = 0;
            bit_pos   = 0;
            hi_cnt    = 0;
            seen_low  = 0;
            shape_bad = 0;
            w_bits    = '0;
            mon_mode  = 1;
          end
        end

        if (mon_mode == 1) begin
          if (bit_pos == 0 && !dout) shape_bad = 1;
          if (dout) begin
            if (seen_low) shape_bad = 1;
            else hi_cnt++;
          end else begin
            seen_low = 1;
          end
          if (bit_pos == TBIT - 1) begin
            if (hi_cnt == T1H) begin
              w_bits = {w_bits[10:0], 1'b1};
            end else begin
              if (hi_cnt != T0H) shape_bad = 1;
              w_bits = {w_bits[10:0], 1'b0};
            end
            bit_pos  = 0;
            hi_cnt   = 0;
            seen_low = 0;
            bit_i++;
            if (bit_i == 12) begin
              check("word_data", int'(w_bits), int'(cur.data));
              check("bit_shape", int'(shape_bad), 0);
              w_end = cyc + 1;
              if (!cur.last && sb_q.size() > 0 && sb_q[0].acc < w_end) begin
                gap_e    = w_end - 1;    // next word must follow with no gap
                busy_cyc = -1;
              end else begin
                gap_e    = w_end + TLATCH;
                busy_cyc = gap_e;
                if (!cur.last) under_cyc = w_end;
              end
              mon_mode = 0;
            end
          end else begin
            bit_pos++;
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    int          n, d;
    logic [11:0] rd;
    logic        rl;

    rst      = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    wr_last  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", int'(dout), 0);
    check("rst_ready", int'(wr_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_underrun", int'(underrun), 0);
    rst = 1'b1;
    @(negedge clk);

    // Single terminated word
    send(12'hA50, 1'b1);
    wait_idle(400);

    // Three words streamed seamlessly
    send(12'hFFF, 1'b0);
    send(12'h000, 1'b0);
    send(12'h123, 1'b1);
    wait_idle(800);

    // Unterminated word with no follow-up
    send(12'h800, 1'b0);
    wait_idle(400);

    // Word written during the latch gap
    send(12'h111, 1'b1);
    repeat (WORD_CYC + 10) @(negedge clk);
    send(12'hABC, 1'b1);
    check("ready_low_in_latch", int'(wr_ready), 0);
    wait_idle(400);

    // Asynchronous reset in the third cycle of a '1' bit, with a word buffered
    send(12'hF0F, 1'b0);
    send(12'h0F0, 1'b1);
    check("pre_rst_dout", int'(dout), 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_dout", int'(dout), 0);
    check("async_rst_ready", int'(wr_ready), 1);
    check("async_rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_dout", int'(dout), 0);
    check("post_rst_ready", int'(wr_ready), 1);
    check("post_rst_busy", int'(busy), 0);
    send(12'h5A5, 1'b1);
    wait_idle(400);

    // Back-pressure: four words with wr_valid held high
    for (int i = 0; i < 4; i++) begin
      rd = 12'($urandom);
      send(rd, 1'(i == 3));
    end
    wait_idle(1000);

    // Random frames with random gaps, including late words and unterminated frames
    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        d = ($urandom_range(0, 5) == 0) ? $urandom_range(60, 140) : $urandom_range(0, 4);
        repeat (d) @(negedge clk);
        rd = 12'($urandom);
        rl = (i == n - 1) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
        send(rd, rl);
      end
      repeat ($urandom_range(0, 100)) @(negedge clk);
    end
    wait_idle(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
